// File: rtl/muldiv_ctrl_if.sv
// Handshake and HI/LO bus of the iterative multiply/divide controller.
// The master side issues operations and mthi/mtlo writes; the slave side is the controller.
interface muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative 32-bit mult/multu/div/divu unit with a fixed 35-cycle issue-to-done latency.
// One 33-bit adder is shared by the shift-add multiply and the restoring divide.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  op_r;
  logic [31:0] acc_r;
  logic [31:0] lo_r;
  logic [31:0] opd_r;
  logic [4:0]  cnt_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        dz_r;
  logic [31:0] hi_out_r;
  logic [31:0] lo_out_r;
  logic        busy_r;
  logic        done_r;
  logic        div_zero_r;

  logic        accept_s;
  logic        is_div_s;
  logic        is_signed_s;
  logic [32:0] add_a_s;
  logic [32:0] add_b_s;
  logic        add_cin_s;
  logic [32:0] sum_s;
  logic [63:0] prod_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    logic [31:0] r;
    if (sgn && v[31]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic flip);
    logic [31:0] r;
    if (flip) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign is_div_s    = op_r[1];
  assign is_signed_s = ~op_r[0];
  assign accept_s    = bus.start && ((state_r == IDLE) || (state_r == DONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = PREP;
        else           state_s = IDLE;
      end
      PREP: state_s = RUN;
      RUN: begin
        if (cnt_r == 5'd31) state_s = FIX;
        else                state_s = RUN;
      end
      FIX: state_s = DONE;
      DONE: begin
        if (bus.start) state_s = PREP;
        else           state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Shared adder: multiply adds the multiplicand when the low bit is set; divide subtracts the divisor
  // from the remainder shifted left by one dividend bit (bit 32 of the sum is the borrow).
  always_comb begin
    if (is_div_s) begin
      add_a_s   = {acc_r, lo_r[31]};
      add_b_s   = ~{1'b0, opd_r};
      add_cin_s = 1'b1;
    end else begin
      add_a_s   = {1'b0, acc_r};
      add_b_s   = lo_r[0] ? {1'b0, opd_r} : 33'd0;
      add_cin_s = 1'b0;
    end
    sum_s = add_a_s + add_b_s + {32'd0, add_cin_s};
  end

  // Sign correction of the unsigned magnitude result
  always_comb begin
    prod_s = {acc_r, lo_r};
    if (neg_q_r) begin
      prod_s = ~{acc_r, lo_r} + 64'd1;
    end else begin
      prod_s = {acc_r, lo_r};
    end
    if (is_div_s) begin
      fix_hi_s = neg32(acc_r, neg_r_r);
      fix_lo_s = neg32(lo_r, neg_q_r);
    end else begin
      fix_hi_s = prod_s[63:32];
      fix_lo_s = prod_s[31:0];
    end
  end

  // Operand latch, magnitude preparation and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 2'd0;
      acc_r   <= 32'd0;
      lo_r    <= 32'd0;
      opd_r   <= 32'd0;
      cnt_r   <= 5'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            op_r  <= bus.op;
            lo_r  <= bus.a;
            opd_r <= bus.b;
          end
        end
        PREP: begin
          lo_r    <= mag32(lo_r, is_signed_s);
          opd_r   <= mag32(opd_r, is_signed_s);
          acc_r   <= 32'd0;
          cnt_r   <= 5'd0;
          neg_q_r <= is_signed_s & (lo_r[31] ^ opd_r[31]);
          neg_r_r <= is_signed_s & lo_r[31];
          dz_r    <= is_div_s & (opd_r == 32'd0);
        end
        RUN: begin
          cnt_r <= cnt_r + 5'd1;
          if (is_div_s) begin
            acc_r <= sum_s[32] ? add_a_s[31:0] : sum_s[31:0];
            lo_r  <= {lo_r[30:0], ~sum_s[32]};
          end else begin
            acc_r <= sum_s[32:1];
            lo_r  <= {sum_s[0], lo_r[31:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Architectural HI/LO: software writes when not busy, result write on leaving FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_out_r <= 32'd0;
      lo_out_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.hi_we) hi_out_r <= bus.wdata;
          if (bus.lo_we) lo_out_r <= bus.wdata;
        end
        FIX: begin
          if (!dz_r) begin
            hi_out_r <= fix_hi_s;
            lo_out_r <= fix_lo_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered status outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r     <= (state_s == PREP) || (state_s == RUN) || (state_s == FIX);
      done_r     <= (state_s == DONE);
      div_zero_r <= (state_s == DONE) && dz_r;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_out_r;
  assign bus.lo       = lo_out_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: table of operations with hand-computed results,
// plus sequences for busy-time Start/HiWe, back-to-back issue and mid-operation reset.
module tb_muldiv_ctrl;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;
  localparam int         LAT   = 34;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  vec_t vecs [13];

  muldiv_ctrl_if bus ();

  muldiv_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    bus.hi_we = 1'b1;
    bus.wdata = h;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = l;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
  endtask

  // Issues an op at the next edge and returns the number of edges until Done is seen (-1 on timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    bit  seen_done;
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{DIVU,  32'd100,      32'h00000000, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b1};
    vecs[5]  = '{MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[6]  = '{MULTU, 32'h12345678, 32'h00000010, 32'h0, 32'h0, 32'h00000001, 32'h23456780, 1'b0};
    vecs[7]  = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0, 32'h0, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[8]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{DIV,   32'h00000000, 32'h00000005, 32'h9, 32'h9, 32'h00000000, 32'h00000000, 1'b0};
    vecs[10] = '{DIV,   32'h00000005, 32'h00000000, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'h55555555, 1'b1};
    vecs[11] = '{MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h00000000, 1'b0};
    vecs[12] = '{DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h80000000, 32'h00000000, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = 32'd0;
    #12;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_dz",   {63'd0, bus.div_zero}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 13; v++) begin
      write_hilo(vecs[v].pre_hi, vecs[v].pre_lo);
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, lat);
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_hilo", v), {bus.hi, bus.lo}, {vecs[v].exp_hi, vecs[v].exp_lo});
      check($sformatf("vec%0d_dz", v), {63'd0, bus.div_zero}, {63'd0, vecs[v].exp_dz});
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", v), {62'd0, bus.done, bus.div_zero}, 64'd0);
    end

    // HiWe coincident with accepted Start writes; Start and HiWe while busy are ignored.
    bus.start = 1'b1;
    bus.op    = MULT;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_hold_hi", {31'd0, bus.busy, bus.hi}, {31'd0, 1'b1, 32'h12345678});
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = DIVU;
    bus.a     = 32'd99;
    bus.b     = 32'd0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check("busy_hi_we_ignored", {32'd0, bus.hi}, {32'd0, 32'h12345678});
    lat = -1;
    for (int i = 11; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check("busy_start_latency", 64'(lat), 64'(LAT));
    check("busy_start_result", {bus.hi, bus.lo}, {32'h0, 32'd15});
    check("busy_start_dz", {63'd0, bus.div_zero}, 64'd0);
    @(posedge clk); #1;
    check("busy_start_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // Back-to-back: second Start accepted while in DONE.
    run_op(MULTU, 32'd6, 32'd7, lat);
    check("b2b_first_latency", 64'(lat), 64'(LAT));
    check("b2b_first_result", {bus.hi, bus.lo}, {32'h0, 32'd42});
    run_op(DIV, 32'hFFFFFF9C, 32'd7, lat);
    check("b2b_second_latency", 64'(lat), 64'(LAT));
    check("b2b_second_result", {bus.hi, bus.lo}, {32'hFFFFFFFE, 32'hFFFFFFF2});

    // Reset 20 edges into an operation.
    write_hilo(32'hCAFE0000, 32'h0000BABE);
    bus.start = 1'b1;
    bus.op    = MULTU;
    bus.a     = 32'h00010000;
    bus.b     = 32'h00010000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", {62'd0, bus.busy, bus.done}, 64'd0);
    check("mid_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    #2;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check("post_reset_no_done", {63'd0, seen_done}, 64'd0);
    check("post_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    run_op(DIVU, 32'd100, 32'd7, lat);
    check("post_reset_latency", 64'(lat), 64'(LAT));
    check("post_reset_result", {bus.hi, bus.lo}, {32'd2, 32'd14});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
